// File: rtl/seq_mult_16.sv
// ---------------------------------------------------------------------------
// seq_mult_16 -- unsigned 16x16 -> 32-bit sequential shift-and-add multiplier
//
// One partial-product add per clock through a single full_adder_16 instance.
// The control unit issues a multiply with `start` while the unit is idle,
// watches `busy`, and picks up `product` in the cycle `done` pulses.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   multiply request, sampled only while idle
//   a        in  16   multiplicand, captured on the accepting edge
//   b        in  16   multiplier, captured on the accepting edge
//   busy     out  1   high while iterating
//   done     out  1   one-cycle pulse, product valid in that cycle
//   product  out 32   result, held from done until the next accepted start
//
// Build option:
//   SEQ_MULT_ZERO_SKIP_EN  when defined, a zero operand skips the iterations
//                          and finishes one cycle after acceptance.
// ---------------------------------------------------------------------------

module full_adder_16 (
    input  logic [15:0] inp1,
    input  logic [15:0] inp2,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] total_s;

    // 17-bit add so the carry out of bit 15 is kept.
    always_comb begin
        total_s = {1'b0, inp1} + {1'b0, inp2} + {16'd0, cin};
    end

    assign sum  = total_s[15:0];
    assign cout = total_s[16];

endmodule

module seq_mult_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [15:0] mcand_r;
    logic [15:0] acc_r;
    logic [15:0] mq_r;
    logic [3:0]  cnt_r;

    logic        busy_r;
    logic        done_r;
    logic        busy_nxt_s;
    logic        done_nxt_s;

    logic [15:0] addend_s;
    logic [15:0] sum_s;
    logic        cout_s;

`ifdef SEQ_MULT_ZERO_SKIP_EN
    logic        zero_op_s;

    // A zero operand means a zero product, so the iterations can be skipped.
    always_comb begin
        zero_op_s = (a == 16'd0) || (b == 16'd0);
    end
`endif

    // Partial product: add the multiplicand only when the current multiplier bit is set.
    always_comb begin
        if (mq_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = 16'd0;
        end
    end

    full_adder_16 u_adder (
        .inp1 (acc_r),
        .inp2 (addend_s),
        .cin  (1'b0),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start is only looked at while idle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
`ifdef SEQ_MULT_ZERO_SKIP_EN
                    if (zero_op_s) begin
                        state_nxt_s = S_DONE;
                    end else begin
                        state_nxt_s = S_RUN;
                    end
`else
                    state_nxt_s = S_RUN;
`endif
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_r == 4'd15) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so busy/done come straight from flops.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            S_IDLE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
            S_RUN: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b0;
            end
            S_DONE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Output flops for busy and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Datapath: operand capture on acceptance, one shift-and-add per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r <= 16'd0;
            acc_r   <= 16'd0;
            mq_r    <= 16'd0;
            cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        mcand_r <= a;
                        acc_r   <= 16'd0;
                        cnt_r   <= 4'd0;
`ifdef SEQ_MULT_ZERO_SKIP_EN
                        if (zero_op_s) begin
                            mq_r <= 16'd0;
                        end else begin
                            mq_r <= b;
                        end
`else
                        mq_r    <= b;
`endif
                    end else begin
                        mcand_r <= mcand_r;
                        acc_r   <= acc_r;
                        mq_r    <= mq_r;
                        cnt_r   <= cnt_r;
                    end
                end
                S_RUN: begin
                    // The carry becomes the new acc MSB, sum[0] shifts into mq.
                    acc_r <= {cout_s, sum_s[15:1]};
                    mq_r  <= {sum_s[0], mq_r[15:1]};
                    cnt_r <= cnt_r + 4'd1;
                end
                S_DONE: begin
                    mcand_r <= mcand_r;
                    acc_r   <= acc_r;
                    mq_r    <= mq_r;
                    cnt_r   <= cnt_r;
                end
                default: begin
                    mcand_r <= 16'd0;
                    acc_r   <= 16'd0;
                    mq_r    <= 16'd0;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = {acc_r, mq_r};

endmodule

// File: tb/tb_seq_mult_16.sv
module tb_seq_mult_16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks;
    int errors;
    int done_cnt;
    int accepted;

    seq_mult_16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done; returns cycles since the accepting edge and busy-cycle count.
    task automatic wait_done(output int lat, output int busy_cycles);
        int n;
        n = 0;
        busy_cycles = 0;
        while (!done && n < 40) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            n++;
        end
        lat = n;
        chk32("done_timeout", {31'd0, done}, 32'd1);
    endtask

    // One multiply: pulse start for one cycle, wait for done, check result, latency and hold.
    task automatic run_mult(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                            input logic [31:0] exp, input int exp_lat);
        int lat;
        int bc;
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'hA5A5; b = 16'h5A5A;
        accepted++;
        wait_done(lat, bc);
        chk32({tag, "_product"}, product, exp);
        chk32({tag, "_latency"}, lat, exp_lat);
        chk32({tag, "_busy_cycles"}, bc, exp_lat);
        chk32({tag, "_busy_with_done"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk32({tag, "_done_fall"}, {31'd0, done}, 32'd0);
        chk32({tag, "_held"}, product, exp);
    endtask

    initial begin
        int lat;
        int bc;
        int zlat;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] rexp;
        checks = 0; errors = 0; done_cnt = 0; accepted = 0;
        rst_n = 1'b0; start = 1'b0; a = 16'd0; b = 16'd0;
`ifdef SEQ_MULT_ZERO_SKIP_EN
        zlat = 0;
`else
        zlat = 16;
`endif
        #1;
        chk32("reset_busy", {31'd0, busy}, 32'd0);
        chk32("reset_done", {31'd0, done}, 32'd0);
        chk32("reset_product", product, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_mult("m3x5", 16'd3, 16'd5, 32'h0000000F, 16);
        run_mult("mffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16);
        run_mult("m0x1234", 16'h0000, 16'h1234, 32'h00000000, zlat);
        run_mult("m1234x0", 16'h1234, 16'h0000, 32'h00000000, zlat);
        run_mult("m1x8000", 16'h0001, 16'h8000, 32'h00008000, 16);

        // start held high with operands changed mid-run: no disturbance, second op accepted afterwards.
        a = 16'h00FF; b = 16'h0100; start = 1'b1;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF;
        wait_done(lat, bc);
        chk32("held_first_product", product, 32'h0000FF00);
        chk32("held_first_latency", lat, 16);
        @(posedge clk); #1;
        chk32("held_done_single", {31'd0, done}, 32'd0);
        // Next edge accepts the second operation with start still high.
        @(posedge clk); #1;
        start = 1'b0;
        chk32("held_second_busy", {31'd0, busy}, 32'd1);
        wait_done(lat, bc);
        chk32("held_second_product", product, 32'hFFFE0001);
        accepted += 2;
        @(posedge clk); #1;

        // Reset in the middle of a run.
        a = 16'h1234; b = 16'h5678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk32("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk32("abort_busy", {31'd0, busy}, 32'd0);
        chk32("abort_done", {31'd0, done}, 32'd0);
        chk32("abort_product", product, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk32("abort_no_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_mult("m2x7", 16'd2, 16'd7, 32'h0000000E, 16);

        // Random operand pairs back-to-back.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rexp = {16'd0, ra} * {16'd0, rb};
            a = ra; b = rb; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            accepted++;
            wait_done(lat, bc);
            checks++;
            assert (product === rexp) else begin
                errors++;
                $error("FAIL rand_product a=%h b=%h observed=%h expected=%h", ra, rb, product, rexp);
            end
            @(posedge clk); #1;
        end

        @(posedge clk); #1;
        chk32("done_count", done_cnt, accepted);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
